otter_dmem_resp: RTL and testbench
==================================

OTTER_DMEM_RESP -- requirements
Module: otter_dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 16384, meaning the number of 32-bit data words.
REQ-002 SHALL have parameter WAIT_STATES, default 0, range 0..7, meaning the extra cycles before each access completes.
REQ-003 SHALL have parameter IO_BASE, default 32'h1100_0000, meaning the first MMIO byte address.
REQ-004 SHALL have port CLK  in  1  clock, rising edge.
REQ-005 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port REQ_ADDR  in  32  byte address.
REQ-007 SHALL have port REQ_WDATA  in  32  store data, right-aligned.
REQ-008 SHALL have ports REQ_WE and REQ_RE  in  1 each  write request and read request.
REQ-009 SHALL have ports REQ_SIZE  in  2  (0 byte, 1 half, 2 word) and REQ_SIGN  in  1  (1 = sign-extend loads).
REQ-010 SHALL have port STALL  out  1  initiator must hold the request while high.
REQ-011 SHALL have ports RSP_VALID  out  1, RSP_RDATA  out  32, and RSP_ERR  out  1, meaning response pulse, load data, and fault.
REQ-012 SHALL have ports IO_IN  in  32, IO_OUT  out  32, and IO_WR  out  1, meaning the MMIO read value, MMIO write register, and MMIO write strobe.

Function
REQ-013 SHALL implement an FSM with states IDLE, WAIT and RESP; a request (REQ_WE|REQ_RE) is accepted at a rising edge while in IDLE or RESP.
REQ-014 SHALL, when WAIT_STATES=0, perform the access at the accepting edge and enter RESP, so RSP_VALID is high the following cycle and STALL is never asserted.
REQ-015 SHALL, when WAIT_STATES>0, load a counter with WAIT_STATES-1 at acceptance and enter WAIT; the counter decrements each edge; when it reaches 0 the access is performed and the state becomes RESP.
REQ-016 SHALL assert STALL combinationally in an accepting cycle when WAIT_STATES>0 and throughout WAIT, and SHALL deassert it in the RESP cycle, giving a total latency of WAIT_STATES+1 cycles.
REQ-017 SHALL latch address, data, size, sign and the request type at acceptance and ignore changes on the REQ_* inputs until RESP.
REQ-018 SHALL pulse RSP_VALID for exactly one cycle per accepted request, for both loads and stores; RSP_RDATA SHALL be 0 for stores.
REQ-019 SHALL select the load byte or halfword from lane REQ_ADDR[1:0] and then zero-extend it, or sign-extend it when REQ_SIGN=1.
REQ-020 SHALL write a store only to the addressed byte lanes and leave the other lanes unchanged.
REQ-021 SHALL treat a misaligned half access (addr[0]=1) or a misaligned word access (addr[1:0]!=0) as a fault: no memory change, RSP_ERR=1, RSP_RDATA=0.
REQ-022 SHALL treat an address below IO_BASE with word index >= DEPTH_WORDS, or REQ_SIZE=3, as a fault with the same behaviour as REQ-021.
REQ-023 SHALL, when REQ_WE and REQ_RE are both high, perform the write, set RSP_ERR=1 and return RSP_RDATA=0.
REQ-024 SHALL transition from RESP with no new request to IDLE on the next edge, so back-to-back requests complete every cycle when WAIT_STATES=0.
REQ-025 SHALL assert RSP_ERR only in a cycle where RSP_VALID is high.

Reset
REQ-026 SHALL, while RST is high, force state IDLE, counter 0, STALL=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, IO_OUT=0 and IO_WR=0.
REQ-027 SHALL abort any pending access when RST is asserted mid-operation (in WAIT), with no memory or IO_OUT update and no response after reset is released.
REQ-028 SHALL NOT clear memory contents on reset.

Configuration
REQ-029 SHALL, when OTTER_DMEM_IO_EN is defined, route addresses >= IO_BASE to MMIO: a store loads IO_OUT with the full word and pulses IO_WR for the RESP cycle; a load returns IO_IN sampled at the perform edge.
REQ-030 SHALL, when OTTER_DMEM_IO_EN is undefined, treat addresses >= IO_BASE as faults, tie IO_OUT to 0 and IO_WR to 0, and ignore IO_IN.

Structure
REQ-031 SHALL take the state enum, the size encoding constants and the default IO_BASE from shared package otter_dmem_pkg.
REQ-032 SHALL place lane extraction and store byte-enable generation in sub-module otter_dmem_align.

Verification
REQ-033 SHALL cover this scenario with WAIT_STATES=0: store word 0xDEADBEEF to 0x100, then load word from 0x100 -> RSP_VALID on the cycle after each request, load RSP_RDATA=0xDEADBEEF, STALL never high.
REQ-034 SHALL cover this scenario: after REQ-033, load byte 0x103 with SIGN=1 -> 0xFFFFFFDE; load half 0x100 with SIGN=0 -> 0x0000BEEF; store byte 0x55 to 0x101 then load word -> 0xDEAD55EF.
REQ-035 SHALL cover this scenario with WAIT_STATES=3: a load request -> STALL high for 3 cycles, RSP_VALID on the 4th cycle, request inputs changed during STALL ignored.
REQ-036 SHALL cover this scenario: load half 0x101, store word 0x102, REQ_SIZE=3, and REQ_WE&REQ_RE together -> RSP_ERR=1 each time with memory unchanged, except the write in the WE&RE case.
REQ-037 SHALL cover this scenario with OTTER_DMEM_IO_EN: store 0x12345678 to IO_BASE -> IO_OUT=0x12345678 with one IO_WR pulse; load IO_BASE with IO_IN=0xA5A5A5A5 -> RSP_RDATA=0xA5A5A5A5; without the macro the same store -> RSP_ERR=1 and IO_WR stays 0.
REQ-038 SHALL cover this scenario with WAIT_STATES=3: assert RST during WAIT of a store to 0x200 -> all outputs 0 immediately, no RSP_VALID afterwards, and a later load of 0x200 returns the old value.

Source files
------------

// File: rtl/otter_dmem_pkg.sv
// Shared definitions for the OTTER data-memory responder: FSM state
// encoding, access-size encoding, default MMIO base and an alignment helper.
package otter_dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_BAD  = 2'd3;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

  // Half accesses need an even address, word accesses a 4-byte aligned one.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic r;
    case (size)
      SIZE_HALF: r = lo[0];
      SIZE_WORD: r = (lo != 2'b00);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/otter_dmem_align.sv
// Byte-lane steering: extracts and extends load data from a memory word and
// builds the replicated store word plus its per-lane byte enables.
module otter_dmem_align
  import otter_dmem_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wword,
  output logic [3:0]  o_be
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane and zero- or sign-extend it to 32 bits.
  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];
    case (i_size)
      SIZE_BYTE: o_rdata = {{24{i_sign & w_byte[7]}}, w_byte};
      SIZE_HALF: o_rdata = {{16{i_sign & w_half[15]}}, w_half};
      default:   o_rdata = i_rword;
    endcase
  end

  // Replicate store data onto every lane; the enables choose which lanes land.
  always_comb begin
    case (i_size)
      SIZE_BYTE: begin
        o_wword = {4{i_wdata[7:0]}};
        o_be    = 4'b0001 << i_lane;
      end
      SIZE_HALF: begin
        o_wword = {2{i_wdata[15:0]}};
        o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_WORD: begin
        o_wword = i_wdata;
        o_be    = 4'b1111;
      end
      default: begin
        o_wword = i_wdata;
        o_be    = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/otter_dmem_resp.sv
// OTTER data memory with a single-request IDLE/WAIT/RESP handshake,
// optional wait states, fault reporting and an MMIO window above IO_BASE.
// Build option: define OTTER_DMEM_IO_EN to enable the MMIO window; without
// it, accesses at or above IO_BASE fault and IO_OUT/IO_WR are tied low.
module otter_dmem_resp
  import otter_dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 16384,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT
)(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  input  logic        REQ_WE,
  input  logic        REQ_RE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGN,
  output logic        STALL,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  input  logic [31:0] IO_IN,
  output logic [31:0] IO_OUT,
  output logic        IO_WR
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0] CNT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_sign;
  logic        r_we;
  logic        r_re;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_perform;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic [1:0]       w_size;
  logic             w_sign;
  logic             w_we;
  logic             w_re;
  logic             w_is_io;
  logic             w_oob;
  logic             w_io_fault;
  logic             w_fault;
  logic             w_mem_sel;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rword;
  logic [31:0]      w_ld_data;
  logic [31:0]      w_wword;
  logic [3:0]       w_be;
  logic [31:0]      w_io_rd;

  assign w_accept = (REQ_WE | REQ_RE) && ((r_state == ST_IDLE) || (r_state == ST_RESP));

  // Zero wait states perform straight from the request pins at the accepting
  // edge; otherwise the access runs later from the copy latched at acceptance.
  assign w_addr  = (WAIT_STATES == 0) ? REQ_ADDR  : r_addr;
  assign w_wdata = (WAIT_STATES == 0) ? REQ_WDATA : r_wdata;
  assign w_size  = (WAIT_STATES == 0) ? REQ_SIZE  : r_size;
  assign w_sign  = (WAIT_STATES == 0) ? REQ_SIGN  : r_sign;
  assign w_we    = (WAIT_STATES == 0) ? REQ_WE    : r_we;
  assign w_re    = (WAIT_STATES == 0) ? REQ_RE    : r_re;

  assign w_perform = !RST && ((WAIT_STATES == 0) ? w_accept
                                                 : ((r_state == ST_WAIT) && (r_cnt == 3'd0)));

  assign w_is_io = (w_addr >= IO_BASE);
  assign w_oob   = !w_is_io && ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));

`ifdef OTTER_DMEM_IO_EN
  assign w_io_fault = 1'b0;
  assign w_io_rd    = IO_IN;
`else
  logic w_unused_io;
  assign w_io_fault  = w_is_io;
  assign w_io_rd     = 32'd0;
  assign w_unused_io = ^IO_IN;
`endif

  assign w_fault   = (w_size == SIZE_BAD) | misaligned(w_size, w_addr[1:0]) | w_oob | w_io_fault;
  assign w_mem_sel = !w_fault && !w_is_io;
  assign w_idx     = w_addr[IDX_W+1:2];
  assign w_rword   = r_mem[w_idx];

  otter_dmem_align u_align (
    .i_lane  (w_addr[1:0]),
    .i_size  (w_size),
    .i_sign  (w_sign),
    .i_rword (w_rword),
    .i_wdata (w_wdata),
    .o_rdata (w_ld_data),
    .o_wword (w_wword),
    .o_be    (w_be)
  );

  assign STALL     = !RST && (WAIT_STATES != 0) && (w_accept || (r_state == ST_WAIT));
  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rsp_rdata;
  assign RSP_ERR   = r_rsp_err;

  // Byte-lane memory write; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (w_perform && w_we && w_mem_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
      end
    end
  end

  // Handshake FSM, request latch and registered response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_size      <= SIZE_BYTE;
      r_sign      <= 1'b0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_perform;
      r_rsp_err   <= w_perform && (w_fault || (w_we && w_re));
      r_rsp_rdata <= 32'd0;
      if (w_perform && !w_fault && w_re && !w_we)
        r_rsp_rdata <= w_is_io ? w_io_rd : w_ld_data;

      if (w_accept) begin
        r_addr  <= REQ_ADDR;
        r_wdata <= REQ_WDATA;
        r_size  <= REQ_SIZE;
        r_sign  <= REQ_SIGN;
        r_we    <= REQ_WE;
        r_re    <= REQ_RE;
      end

      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_accept) begin
            if (WAIT_STATES == 0) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) r_state <= ST_RESP;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef OTTER_DMEM_IO_EN
  logic [31:0] r_io_out;
  logic        r_io_wr;

  // MMIO write register and single-cycle strobe aligned with the response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_io_out <= 32'd0;
      r_io_wr  <= 1'b0;
    end else begin
      r_io_wr <= 1'b0;
      if (w_perform && w_we && !w_fault && w_is_io) begin
        r_io_out <= w_wdata;
        r_io_wr  <= 1'b1;
      end
    end
  end

  assign IO_OUT = r_io_out;
  assign IO_WR  = r_io_wr;
`else
  assign IO_OUT = 32'd0;
  assign IO_WR  = 1'b0;
`endif

endmodule

// File: tb/tb_otter_dmem_resp.sv
// Directed bench for otter_dmem_resp: one zero-wait instance and one
// three-wait-state instance, hand-computed expectations throughout.
module tb_otter_dmem_resp;

  localparam logic [31:0] IO_BASE = 32'h1100_0000;

  logic        clk = 1'b0;
  logic        rst0, rst3;
  logic        we0, re0, sign0, we3, re3, sign3;
  logic [1:0]  size0, size3;
  logic [31:0] addr0, wdata0, io_in0, addr3, wdata3, io_in3;
  logic        stall0, valid0, err0, io_wr0, stall3, valid3, err3, io_wr3;
  logic [31:0] rdata0, io_out0, rdata3, io_out3;

  int   n_chk = 0;
  int   n_err = 0;
  logic        last_io_wr;
  logic [31:0] last_io_out;
  logic        seen;

  always #5 clk = ~clk;

  otter_dmem_resp #(.WAIT_STATES(0)) dut0 (
    .CLK(clk), .RST(rst0), .REQ_ADDR(addr0), .REQ_WDATA(wdata0), .REQ_WE(we0), .REQ_RE(re0),
    .REQ_SIZE(size0), .REQ_SIGN(sign0), .STALL(stall0), .RSP_VALID(valid0), .RSP_RDATA(rdata0),
    .RSP_ERR(err0), .IO_IN(io_in0), .IO_OUT(io_out0), .IO_WR(io_wr0)
  );

  otter_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
    .CLK(clk), .RST(rst3), .REQ_ADDR(addr3), .REQ_WDATA(wdata3), .REQ_WE(we3), .REQ_RE(re3),
    .REQ_SIZE(size3), .REQ_SIGN(sign3), .STALL(stall3), .RSP_VALID(valid3), .RSP_RDATA(rdata3),
    .RSP_ERR(err3), .IO_IN(io_in3), .IO_OUT(io_out3), .IO_WR(io_wr3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One request on the zero-wait instance followed by one idle cycle.
  task automatic req0(input string tag, input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic sign,
                      input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    we0 = we; re0 = re; addr0 = addr; wdata0 = wdata; size0 = size; sign0 = sign;
    #1 chk1({tag, ".stall"}, stall0, 1'b0);
    @(posedge clk); #1;
    chk1({tag, ".valid"}, valid0, 1'b1);
    chk ({tag, ".rdata"}, rdata0, exp_rd);
    chk1({tag, ".err"},   err0,   exp_err);
    last_io_wr  = io_wr0;
    last_io_out = io_out0;
    @(negedge clk);
    we0 = 1'b0; re0 = 1'b0;
    @(posedge clk); #1;
    chk1({tag, ".drop"}, valid0, 1'b0);
    chk1({tag, ".errdrop"}, err0, 1'b0);
  endtask

  // One request on the three-wait instance; inputs are scrambled while stalled.
  task automatic req3(input string tag, input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic [31:0] exp_rd);
    @(negedge clk);
    we3 = we; re3 = re; addr3 = addr; wdata3 = wdata; size3 = size; sign3 = 1'b0;
    #1 chk1({tag, ".stall0"}, stall3, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk1({tag, ".stall"}, stall3, 1'b1);
      chk1({tag, ".nov"},   valid3, 1'b0);
      @(negedge clk);
      if (k < 3) begin
        we3 = re; re3 = we; addr3 = 32'h204; wdata3 = 32'hBADBAD00;
        size3 = 2'd0; sign3 = 1'b1;
      end else begin
        we3 = 1'b0; re3 = 1'b0;
      end
      @(posedge clk);
    end
    #1;
    chk1({tag, ".stallrsp"}, stall3, 1'b0);
    chk1({tag, ".valid"},    valid3, 1'b1);
    chk ({tag, ".rdata"},    rdata3, exp_rd);
    chk1({tag, ".err"},      err3,   1'b0);
    @(posedge clk); #1;
    chk1({tag, ".drop"}, valid3, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    we0 = 0; re0 = 0; sign0 = 0; size0 = 2'd2; addr0 = 0; wdata0 = 0; io_in0 = 32'hA5A5A5A5;
    we3 = 0; re3 = 0; sign3 = 0; size3 = 2'd2; addr3 = 0; wdata3 = 0; io_in3 = 32'h0;
    #1;
    chk1("rst.stall0", stall0, 1'b0);  chk1("rst.valid0", valid0, 1'b0);
    chk ("rst.rdata0", rdata0, 32'h0); chk1("rst.err0", err0, 1'b0);
    chk ("rst.ioout0", io_out0, 32'h0); chk1("rst.iowr0", io_wr0, 1'b0);
    chk1("rst.stall3", stall3, 1'b0);  chk1("rst.valid3", valid3, 1'b0);
    repeat (2) @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;

    // Basic store/load and lane handling
    req0("st_w",   1, 0, 32'h100, 32'hDEADBEEF, 2'd2, 0, 32'h0,        0);
    req0("ld_w",   0, 1, 32'h100, 32'h0,        2'd2, 0, 32'hDEADBEEF, 0);
    req0("ld_bs",  0, 1, 32'h103, 32'h0,        2'd0, 1, 32'hFFFFFFDE, 0);
    req0("ld_hu",  0, 1, 32'h100, 32'h0,        2'd1, 0, 32'h0000BEEF, 0);
    req0("ld_bu",  0, 1, 32'h100, 32'h0,        2'd0, 0, 32'h000000EF, 0);
    req0("ld_hs",  0, 1, 32'h102, 32'h0,        2'd1, 1, 32'hFFFFDEAD, 0);

    // Back-to-back: byte store then word load on consecutive cycles
    @(negedge clk);
    we0 = 1; re0 = 0; addr0 = 32'h101; wdata0 = 32'h00000055; size0 = 2'd0; sign0 = 0;
    @(posedge clk); #1;
    chk1("b2b.st.valid", valid0, 1'b1);
    chk ("b2b.st.rdata", rdata0, 32'h0);
    @(negedge clk);
    we0 = 0; re0 = 1; addr0 = 32'h100; size0 = 2'd2;
    #1 chk1("b2b.ld.stall", stall0, 1'b0);
    @(posedge clk); #1;
    chk1("b2b.ld.valid", valid0, 1'b1);
    chk ("b2b.ld.rdata", rdata0, 32'hDEAD55EF);
    @(negedge clk);
    re0 = 0;
    @(posedge clk); #1;
    chk1("b2b.drop", valid0, 1'b0);

    // Faults leave memory alone; WE&RE still writes
    req0("f_half", 0, 1, 32'h101, 32'h0,        2'd1, 0, 32'h0, 1);
    req0("f_word", 1, 0, 32'h102, 32'h11111111, 2'd2, 0, 32'h0, 1);
    req0("f_sz3",  1, 0, 32'h100, 32'h22222222, 2'd3, 0, 32'h0, 1);
    req0("f_chk",  0, 1, 32'h100, 32'h0,        2'd2, 0, 32'hDEAD55EF, 0);
    req0("f_both", 1, 1, 32'h104, 32'hCAFEF00D, 2'd2, 0, 32'h0, 1);
    req0("f_bchk", 0, 1, 32'h104, 32'h0,        2'd2, 0, 32'hCAFEF00D, 0);
    req0("f_oob",  0, 1, 32'h00010000, 32'h0,   2'd2, 0, 32'h0, 1);
    req0("top_st", 1, 0, 32'h0000FFFC, 32'h0BADF00D, 2'd2, 0, 32'h0, 0);
    req0("top_ld", 0, 1, 32'h0000FFFC, 32'h0,   2'd2, 0, 32'h0BADF00D, 0);

    // MMIO window
`ifdef OTTER_DMEM_IO_EN
    req0("io_st", 1, 0, IO_BASE, 32'h12345678, 2'd2, 0, 32'h0, 0);
    chk1("io_st.wr",    last_io_wr,  1'b1);
    chk ("io_st.out",   last_io_out, 32'h12345678);
    chk1("io_st.wrend", io_wr0,      1'b0);
    chk ("io_st.hold",  io_out0,     32'h12345678);
    req0("io_ld", 0, 1, IO_BASE, 32'h0, 2'd2, 0, 32'hA5A5A5A5, 0);
`else
    req0("io_st", 1, 0, IO_BASE, 32'h12345678, 2'd2, 0, 32'h0, 1);
    chk1("io_st.wr",  last_io_wr,  1'b0);
    chk ("io_st.out", last_io_out, 32'h0);
    req0("io_ld", 0, 1, IO_BASE, 32'h0, 2'd2, 0, 32'h0, 1);
`endif

    // Wait states with inputs changing during the stall
    req3("w3_st", 1, 0, 32'h200, 32'h01020304, 2'd2, 32'h0);
    req3("w3_ld", 0, 1, 32'h200, 32'h0,        2'd2, 32'h01020304);

    // Reset in WAIT aborts the pending store
    @(negedge clk);
    we3 = 1; re3 = 0; addr3 = 32'h200; wdata3 = 32'hFFFFFFFF; size3 = 2'd2;
    @(posedge clk); #1;
    chk1("ab.stall", stall3, 1'b1);
    rst3 = 1'b1;
    #1;
    chk1("ab.rstall", stall3, 1'b0); chk1("ab.rvalid", valid3, 1'b0);
    chk ("ab.rrdata", rdata3, 32'h0); chk1("ab.rerr", err3, 1'b0);
    chk ("ab.rioout", io_out3, 32'h0); chk1("ab.riowr", io_wr3, 1'b0);
    we3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (valid3 || stall3) seen = 1'b1;
    end
    chk1("ab.quiet", seen, 1'b0);
    req3("ab_ld", 0, 1, 32'h200, 32'h0, 2'd2, 32'h01020304);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
